dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter that shares the processor's single-port 32x32 data memory between the MIPS core's load/store path and a host/test port used to preload and dump memory. It selects one requester per cycle, drives the memory port, and returns read data one cycle later to the requester that issued the read. A bounded host lock lets the host perform back-to-back bursts without starving the core.

## Interface
- AW, 5: word-address width (memory depth 2^AW).
- DW, 32: data width.
- BURST_MAX, 8: maximum consecutive cycles a locked host holds the memory while the core is waiting.
- CK  in  1  clock, rising edge.
- RESET  in  1  reset RESET, synchronous, active-high.
- C_REQ, C_WE  in  1  core request and write enable.
- C_ADDR  in  AW  core word address.
- C_WDATA  in  DW  core write data.
- C_GNT  out  1  core access accepted this cycle.
- C_RVALID  out  1  core read data valid.
- C_RDATA  out  DW  core read data.
- H_REQ, H_WE, H_LOCK  in  1  host request, write enable, burst lock.
- H_ADDR  in  AW  host word address.
- H_WDATA  in  DW  host write data.
- H_GNT, H_RVALID  out  1  host grant and read valid.
- H_RDATA  out  DW  host read data.
- M_EN, M_WE  out  1  memory enable and write enable.
- M_ADDR  out  AW  memory address.
- M_WDATA  out  DW  memory write data.
- M_RDATA  in  DW  memory read data, valid one cycle after M_EN with M_WE=0.

## Operation
- Requester holds REQ, WE, ADDR, WDATA stable until it sees GNT; a GNT cycle consumes exactly one access.
- At most one GNT per cycle. M_EN = C_GNT | H_GNT; M_WE/M_ADDR/M_WDATA come from the granted requester, all zero when idle.
- States: IDLE, LOCK_H.
- IDLE: one requester present -> grant it. Both present -> policy per Configuration. Host granted with H_LOCK=1 -> LOCK_H, lock counter cleared to 0.
- LOCK_H: core never granted; host granted whenever H_REQ=1. Counter increments every cycle in LOCK_H while C_REQ=1, saturating at BURST_MAX; it does not increment while C_REQ=0.
- Exit LOCK_H -> IDLE when H_LOCK=0, or when counter = BURST_MAX and C_REQ=1. In the exit cycle, no host grant; core is granted if C_REQ=1.
- H_LOCK while H_REQ=0 in IDLE is ignored.
- Read tag register records owner of each granted read; next cycle the matching RVALID pulses for one cycle, with RDATA = M_RDATA. The other RDATA holds its previous value.
- Writes produce no RVALID.
- Same-address write and read on consecutive cycles are serialized by grant order; no forwarding.

## Timing
- Grant is combinational from REQ and registered state; memory access occurs in the GNT cycle.
- Read latency: RVALID exactly one cycle after GNT. Full throughput: one access per cycle.
- Reset values: all GNT, RVALID, M_EN, M_WE = 0; M_ADDR, M_WDATA, C_RDATA, H_RDATA = 0; state IDLE; counter 0; round-robin pointer = core.
- RESET asserted during a read cycle: RVALID for that read is suppressed. RESET overrides all requests; no GNT while RESET=1.
- Worst-case core wait under a locked host: BURST_MAX + 1 cycles.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin on contention. The pointer flips to the other requester after each contended grant. Uncontested grants leave the pointer unchanged.
- Not defined: fixed priority, core wins every contention in IDLE. The lock mechanism is identical in both builds.

## Structure
- Shared package holds: state enum (IDLE, LOCK_H), owner encoding (OWN_CORE=0, OWN_HOST=1), default AW/DW constants.
- No sub-module required. An optional leaf `arb_rr_pick` (two-input priority/round-robin pick) isolates the macro-dependent logic.

## Test plan
- Core only: C_REQ write addr 3 data 0xDEADBEEF, then read addr 3 -> C_GNT each cycle, C_RVALID next cycle with C_RDATA=0xDEADBEEF, H_* idle.
- Contention, no macro: both read every cycle, 4 cycles -> 4 core grants, 0 host grants. Same with DMEM_ARB_RR_EN -> grants alternate core, host, core, host.
- Host burst: H_LOCK=1, H_REQ writes addr 0..15, C_REQ held from cycle 2, BURST_MAX=8 -> host grants 8 cycles after core arrives, then core granted, then IDLE policy resumes.
- Lock release: host drops H_LOCK after 3 beats with core waiting -> core granted in the next cycle, counter reset.
- Tag routing: host read addr 7 (0x1234) followed by core read addr 8 (0x5678) -> H_RVALID with 0x1234, then C_RVALID with 0x5678, never crossed.
- Reset mid-read: RESET in the cycle after a read GNT -> no RVALID, all outputs 0, state IDLE next cycle.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and default sizing for the data-memory arbiter.
package dmem_arbiter_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCK_H = 1'b1
    } arb_state_t;

    typedef enum logic [0:0] {
        OWN_CORE = 1'b0,
        OWN_HOST = 1'b1
    } owner_t;

    localparam int DMEM_AW        = 5;
    localparam int DMEM_DW        = 32;
    localparam int DMEM_BURST_MAX = 8;

endpackage

// File: rtl/dmem_arbiter.sv
// Core/host arbiter for the single-port data memory with a bounded host burst lock.
// Define DMEM_ARB_RR_EN for round-robin contention; otherwise the core wins every contention.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int AW        = DMEM_AW,
    parameter int DW        = DMEM_DW,
    parameter int BURST_MAX = DMEM_BURST_MAX
) (
    input  logic          CK,
    input  logic          RESET,
    input  logic          C_REQ,
    input  logic          C_WE,
    input  logic [AW-1:0] C_ADDR,
    input  logic [DW-1:0] C_WDATA,
    output logic          C_GNT,
    output logic          C_RVALID,
    output logic [DW-1:0] C_RDATA,
    input  logic          H_REQ,
    input  logic          H_WE,
    input  logic          H_LOCK,
    input  logic [AW-1:0] H_ADDR,
    input  logic [DW-1:0] H_WDATA,
    output logic          H_GNT,
    output logic          H_RVALID,
    output logic [DW-1:0] H_RDATA,
    output logic          M_EN,
    output logic          M_WE,
    output logic [AW-1:0] M_ADDR,
    output logic [DW-1:0] M_WDATA,
    input  logic [DW-1:0] M_RDATA
);

    localparam int CW = $clog2(BURST_MAX + 1);

    arb_state_t    state_r, state_nxt_s;
    logic [CW-1:0] cnt_r, cnt_nxt_s;
    logic          c_gnt_s, h_gnt_s;
    logic          host_wins_s;
    logic          lock_exit_s;
    logic          rd_pend_r;
    owner_t        rd_own_r;
    logic [DW-1:0] c_rdata_r, h_rdata_r;
    logic          c_rvalid_s, h_rvalid_s;

`ifdef DMEM_ARB_RR_EN
    owner_t rr_ptr_r;

    // Round-robin pointer flips only on contended IDLE grants
    always_ff @(posedge CK) begin
        if (RESET) begin
            rr_ptr_r <= OWN_CORE;
        end else if (state_r == IDLE && C_REQ && H_REQ) begin
            rr_ptr_r <= (rr_ptr_r == OWN_CORE) ? OWN_HOST : OWN_CORE;
        end
    end

    assign host_wins_s = (rr_ptr_r == OWN_HOST);
`else
    assign host_wins_s = 1'b0;
`endif

    // A waiting core eventually forces the lock open once the budget is spent
    assign lock_exit_s = !H_LOCK || (C_REQ && (cnt_r == CW'(BURST_MAX)));

    // State and lock counter register
    always_ff @(posedge CK) begin
        if (RESET) begin
            state_r <= IDLE;
            cnt_r   <= {CW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state and lock counter update
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                cnt_nxt_s = {CW{1'b0}};
                if (h_gnt_s && H_LOCK) begin
                    state_nxt_s = LOCK_H;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOCK_H: begin
                if (lock_exit_s) begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = {CW{1'b0}};
                end else if (C_REQ && (cnt_r != CW'(BURST_MAX))) begin
                    cnt_nxt_s = cnt_r + CW'(1);
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = {CW{1'b0}};
            end
        endcase
    end

    // Grant decision
    always_comb begin
        c_gnt_s = 1'b0;
        h_gnt_s = 1'b0;
        if (RESET) begin
            c_gnt_s = 1'b0;
            h_gnt_s = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (C_REQ && H_REQ) begin
                        h_gnt_s = host_wins_s;
                        c_gnt_s = !host_wins_s;
                    end else begin
                        c_gnt_s = C_REQ;
                        h_gnt_s = H_REQ;
                    end
                end
                LOCK_H: begin
                    if (lock_exit_s) begin
                        c_gnt_s = C_REQ;
                    end else begin
                        h_gnt_s = H_REQ;
                    end
                end
                default: begin
                    c_gnt_s = 1'b0;
                    h_gnt_s = 1'b0;
                end
            endcase
        end
    end

    assign C_GNT = c_gnt_s;
    assign H_GNT = h_gnt_s;

    // Memory port follows the granted requester, zero when idle
    always_comb begin
        M_EN    = c_gnt_s | h_gnt_s;
        M_WE    = 1'b0;
        M_ADDR  = {AW{1'b0}};
        M_WDATA = {DW{1'b0}};
        if (c_gnt_s) begin
            M_WE    = C_WE;
            M_ADDR  = C_ADDR;
            M_WDATA = C_WDATA;
        end else if (h_gnt_s) begin
            M_WE    = H_WE;
            M_ADDR  = H_ADDR;
            M_WDATA = H_WDATA;
        end else begin
            M_WE    = 1'b0;
        end
    end

    // Read tag: who owns the read data arriving next cycle
    always_ff @(posedge CK) begin
        if (RESET) begin
            rd_pend_r <= 1'b0;
            rd_own_r  <= OWN_CORE;
        end else begin
            rd_pend_r <= (c_gnt_s && !C_WE) || (h_gnt_s && !H_WE);
            rd_own_r  <= h_gnt_s ? OWN_HOST : OWN_CORE;
        end
    end

    assign c_rvalid_s = rd_pend_r && !RESET && (rd_own_r == OWN_CORE);
    assign h_rvalid_s = rd_pend_r && !RESET && (rd_own_r == OWN_HOST);
    assign C_RVALID   = c_rvalid_s;
    assign H_RVALID   = h_rvalid_s;

    // Read-data hold registers keep the last value returned to each side
    always_ff @(posedge CK) begin
        if (RESET) begin
            c_rdata_r <= {DW{1'b0}};
            h_rdata_r <= {DW{1'b0}};
        end else begin
            if (c_rvalid_s) c_rdata_r <= M_RDATA;
            if (h_rvalid_s) h_rdata_r <= M_RDATA;
        end
    end

    // Return data straight from memory in the valid cycle
    always_comb begin
        C_RDATA = c_rdata_r;
        H_RDATA = h_rdata_r;
        if (RESET) begin
            C_RDATA = {DW{1'b0}};
            H_RDATA = {DW{1'b0}};
        end else begin
            C_RDATA = c_rvalid_s ? M_RDATA : c_rdata_r;
            H_RDATA = h_rvalid_s ? M_RDATA : h_rdata_r;
        end
    end

endmodule
